// File: rtl/picoblaze_event_port.sv
// ---------------------------------------------------------------------------
// picoblaze_event_port
//   PicoBlaze input-port block for the RTC controller. Each of N_CH event
//   inputs is edge-detected into a sticky flag. A second edge on a channel
//   whose flag is still set is recorded as an overflow. A registered
//   decoder/mux presents the flags and overflows on the PicoBlaze in_port.
//   Reads clear what they return.
//
//   Optional feature macro: EVT_IRQ_EN
//     When defined, any new event raises o_irq and i_irq_ack clears it.
//     When undefined, o_irq is tied low and i_irq_ack is ignored.
//
// Ports
//   i_clk          system clock; all logic runs on its rising edge
//   i_rst          asynchronous reset, active-high
//   i_evt_in       [N_CH]   event levels/pulses, synchronous to i_clk
//   i_port_id      [8]      PicoBlaze port_id
//   i_read_strobe           PicoBlaze read_strobe
//   i_irq_ack               PicoBlaze interrupt_ack (EVT_IRQ_EN only)
//   o_data_out     [DATA_W] to PicoBlaze in_port, registered
//   o_irq                   interrupt request, registered
//
// Address map (the port_id compare uses all 8 bits)
//   STATUS_ADDR      -> all flags packed, LSB = ch0  (read clears all flags)
//   BASE_ADDR + i    -> flag[i] in bit 0              (read clears flag[i])
//   OVF_ADDR         -> all overflow bits packed      (read clears all ovf)
// ---------------------------------------------------------------------------

// Per-channel edge detector and sticky flag/overflow state.
module picoblaze_event_chan (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_evt,
    input  logic i_clr_flag,
    input  logic i_clr_ovf,
    output logic o_rise,
    output logic o_flag,
    output logic o_ovf
);
    logic r_evt_d;
    logic r_flag;
    logic r_ovf;
    logic w_rise;
    logic w_ovf_set;

    // r_evt_d resets to 0, so a level held high through reset release
    // still produces exactly one event.
    assign w_rise    = i_evt & ~r_evt_d;
    // A clear on the same edge as a new rise absorbs the rise. The flag
    // stays set and is not counted as a lost event.
    assign w_ovf_set = w_rise & r_flag & ~i_clr_flag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_evt_d <= 1'b0;
            r_flag  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_evt_d <= i_evt;

            if (w_rise)
                r_flag <= 1'b1;
            else if (i_clr_flag)
                r_flag <= 1'b0;

            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (i_clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign o_rise = w_rise;
    assign o_flag = r_flag;
    assign o_ovf  = r_ovf;
endmodule

module picoblaze_event_port #(
    parameter int         N_CH        = 3,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] STATUS_ADDR = 8'h00,
    parameter logic [7:0] BASE_ADDR   = 8'h01,
    parameter logic [7:0] OVF_ADDR    = 8'h0F
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_evt_in,
    input  logic [7:0]        i_port_id,
    input  logic              i_read_strobe,
    input  logic              i_irq_ack,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_irq
);
    logic [N_CH-1:0]   w_rise;
    logic [N_CH-1:0]   w_flag;
    logic [N_CH-1:0]   w_ovf;
    logic [N_CH-1:0]   w_ch_hit;
    logic [N_CH-1:0]   w_clr_flag;
    logic              w_status_hit;
    logic              w_ovf_hit;
    logic              w_clr_ovf;
    logic [DATA_W-1:0] w_mux;
    logic [DATA_W-1:0] r_data_out;

    assign w_status_hit = (i_port_id == STATUS_ADDR);
    assign w_ovf_hit    = (i_port_id == OVF_ADDR);
    assign w_clr_ovf    = i_read_strobe & w_ovf_hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // 8-bit address arithmetic, so the channel decode wraps the same
        // way as port_id does.
        localparam logic [7:0] CH_ADDR = BASE_ADDR + 8'(i);

        assign w_ch_hit[i]   = (i_port_id == CH_ADDR);
        assign w_clr_flag[i] = i_read_strobe & (w_ch_hit[i] | w_status_hit);

        picoblaze_event_chan u_chan (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_evt      (i_evt_in[i]),
            .i_clr_flag (w_clr_flag[i]),
            .i_clr_ovf  (w_clr_ovf),
            .o_rise     (w_rise[i]),
            .o_flag     (w_flag[i]),
            .o_ovf      (w_ovf[i])
        );
    end

    // The mux reads the pre-clear state. The value returned on a
    // read_strobe edge was decoded one cycle earlier, so clearing on that
    // edge never hides an event from the reader.
    always_comb begin
        w_mux = '0;
        if (w_status_hit)
            w_mux[N_CH-1:0] = w_flag;
        else if (w_ovf_hit)
            w_mux[N_CH-1:0] = w_ovf;
        else if (|w_ch_hit)
            w_mux[0] = |(w_ch_hit & w_flag);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_data_out <= '0;
        else
            r_data_out <= w_mux;
    end

    assign o_data_out = r_data_out;

`ifdef EVT_IRQ_EN
    logic r_irq;

    // A new event takes priority over an ack on the same edge, so the
    // second event still raises an interrupt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_irq <= 1'b0;
        else if (|w_rise)
            r_irq <= 1'b1;
        else if (i_irq_ack)
            r_irq <= 1'b0;
    end

    assign o_irq = r_irq;
`else
    logic w_unused_irq;

    assign w_unused_irq = ^{i_irq_ack, w_rise};
    assign o_irq        = 1'b0;
`endif
endmodule

// File: tb/tb_picoblaze_event_port.sv
module tb_picoblaze_event_port;
    localparam int         N_CH   = 3;
    localparam int         DATA_W = 8;
    localparam logic [7:0] STATUS = 8'h00;
    localparam logic [7:0] BASE   = 8'h01;
    localparam logic [7:0] OVFA   = 8'h0F;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   evt;
    logic [7:0]        pid;
    logic              rs;
    logic              ack;
    logic [DATA_W-1:0] dout;
    logic              irq;

    int checks = 0;
    int errors = 0;

    // Reference model state, one bit per channel.
    bit              m_prev [N_CH];
    bit              m_flag [N_CH];
    bit              m_ovf  [N_CH];
    logic [7:0]      m_dout;
    logic            m_irq;

    picoblaze_event_port #(
        .N_CH(N_CH), .DATA_W(DATA_W),
        .STATUS_ADDR(STATUS), .BASE_ADDR(BASE), .OVF_ADDR(OVFA)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_evt_in(evt), .i_port_id(pid),
        .i_read_strobe(rs), .i_irq_ack(ack), .o_data_out(dout), .o_irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_CH; i++) begin
            m_prev[i] = 0; m_flag[i] = 0; m_ovf[i] = 0;
        end
        m_dout = 8'h00;
        m_irq  = 1'b0;
    endtask

    // What the reader sees for a given port_id with the current state.
    function automatic logic [7:0] model_read(input logic [7:0] p);
        logic [7:0] v;
        v = 8'h00;
        if (p == STATUS) begin
            for (int i = 0; i < N_CH; i++) v = v + (m_flag[i] ? (8'h01 << i) : 8'h00);
        end else if (p == OVFA) begin
            for (int i = 0; i < N_CH; i++) v = v + (m_ovf[i] ? (8'h01 << i) : 8'h00);
        end else if (p >= BASE && p < BASE + N_CH) begin
            v = m_flag[p - BASE] ? 8'h01 : 8'h00;
        end
        return v;
    endfunction

    // Advance one clock: update the model from the inputs sampled on this
    // edge, then compare both outputs just after the edge.
    task automatic cycle();
        logic [7:0] nd;
        bit         any_new;
        bit         is_new;
        bit         rd_clear;
        bit         lost;
        @(posedge clk);
        if (!rst) begin
            nd      = model_read(pid);
            any_new = 0;
            for (int i = 0; i < N_CH; i++) begin
                is_new   = evt[i] && !m_prev[i];
                rd_clear = rs && (pid == STATUS || pid == BASE + i);
                lost     = is_new && m_flag[i] && !rd_clear;
                any_new  = any_new || is_new;
                if (is_new)        m_flag[i] = 1;
                else if (rd_clear) m_flag[i] = 0;
                if (lost)                          m_ovf[i] = 1;
                else if (rs && pid == OVFA)        m_ovf[i] = 0;
                m_prev[i] = evt[i];
            end
            m_dout = nd;
`ifdef EVT_IRQ_EN
            if (any_new)  m_irq = 1'b1;
            else if (ack) m_irq = 1'b0;
`else
            m_irq = 1'b0;
`endif
        end
        #1;
        chk("cyc_dout", dout, m_dout);
        chk("cyc_irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_clear();
        chk("rst_async_dout", dout, 8'h00);
        chk("rst_async_irq", {7'b0, irq}, 8'h00);
    endtask

    initial begin
        rst = 1'b1; evt = '0; pid = 8'h00; rs = 1'b0; ack = 1'b0;
        model_clear();

        // 1: reset state
        repeat (4) cycle();
        chk("t1_rst_dout", dout, 8'h00);
        rst = 1'b0;
        pid = STATUS; cycle(); cycle();
        chk("t1_status", dout, 8'h00);
        pid = OVFA; cycle();
        chk("t1_ovf", dout, 8'h00);

        // 2: single pulse, status read clears
        evt = 3'b001; cycle();
        evt = 3'b000; pid = STATUS; cycle();
        chk("t2_status", dout, 8'h01);
        rs = 1'b1; cycle();
        rs = 1'b0; cycle();
        chk("t2_cleared", dout, 8'h00);

        // 3: held level produces one event
        evt = 3'b010; pid = 8'h02;
        repeat (3) cycle();
        chk("t3_flag", dout, 8'h01);
        rs = 1'b1; cycle();
        rs = 1'b0; repeat (3) cycle();
        chk("t3_cleared", dout, 8'h00);
        repeat (13) cycle();
        chk("t3_no_retrig", dout, 8'h00);
        evt = 3'b000; cycle();

        // 4: double event -> overflow
        evt = 3'b100; cycle();
        evt = 3'b000; cycle();
        evt = 3'b100; cycle();
        evt = 3'b000; pid = 8'h03; cycle(); cycle();
        chk("t4_flag", dout, 8'h01);
        pid = OVFA; cycle();
        chk("t4_ovf", dout, 8'h04);
        rs = 1'b1; cycle();
        rs = 1'b0; cycle();
        chk("t4_ovf_cleared", dout, 8'h00);
        pid = 8'h03; rs = 1'b1; cycle();
        rs = 1'b0; cycle();
        chk("t4_flag_cleared", dout, 8'h00);

        // 5: rise coincident with read of the same channel -> set wins
        pid = 8'h01; rs = 1'b1; evt = 3'b001; cycle();
        rs = 1'b0; evt = 3'b000; cycle();
        chk("t5_flag", dout, 8'h01);
        pid = OVFA; cycle();
        chk("t5_ovf", dout, 8'h00);
        // Same, with the flag already set: still no overflow
        pid = 8'h01; rs = 1'b1; evt = 3'b001; cycle();
        rs = 1'b0; evt = 3'b000; cycle();
        chk("t5b_flag", dout, 8'h01);
        pid = OVFA; cycle();
        chk("t5b_ovf", dout, 8'h00);
        pid = 8'h01; rs = 1'b1; cycle();
        rs = 1'b0; cycle();

        // 6: interrupt request
        evt = 3'b010; cycle();
        evt = 3'b000;
`ifdef EVT_IRQ_EN
        chk("t6_irq_set", {7'b0, irq}, 8'h01);
        ack = 1'b1; cycle();
        ack = 1'b0;
        chk("t6_irq_ack", {7'b0, irq}, 8'h00);
        evt = 3'b010; cycle(); cycle();
        ack = 1'b1; evt = 3'b000; cycle();
        evt = 3'b010; ack = 1'b1; cycle();
        chk("t6_irq_race", {7'b0, irq}, 8'h01);
        evt = 3'b000; ack = 1'b0; cycle();
`else
        ack = 1'b1; cycle();
        ack = 1'b0;
        chk("t6_irq_off", {7'b0, irq}, 8'h00);
`endif

        // Mid-operation reset with a level held through release
        pid = STATUS; evt = 3'b001; cycle();
        async_reset();
        repeat (2) cycle();
        rst = 1'b0; pid = STATUS; cycle(); cycle();
        chk("rst_level_event", dout, 8'h01);
        repeat (5) cycle();
        pid = OVFA; cycle();
        chk("rst_level_no_ovf", dout, 8'h00);
        evt = 3'b000; pid = STATUS; rs = 1'b1; cycle();
        rs = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_CH; i++) evt[i] = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: pid = STATUS;
                1: pid = 8'h01;
                2: pid = 8'h02;
                3: pid = 8'h03;
                4: pid = OVFA;
                5: pid = 8'h04;
                default: pid = 8'($urandom);
            endcase
            rs  = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
            if (n == 200) begin
                async_reset();
                cycle();
                rst = 1'b0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
